// File: rtl/product_accum_ctrl_pkg.sv
// Shared types and default sizing for the product/accumulator tile controller.
package product_accum_ctrl_pkg;

    // Default maximum number of partial-product slices in one tile.
    localparam int K_MAX_DEF   = 256;
    // Default width of the completed-tile counter.
    localparam int TILE_CW_DEF = 16;
    // Width needed to hold a slice count of 0..K_MAX_DEF inclusive.
    localparam int KW          = $clog2(K_MAX_DEF + 1);

    // Controller phases: waiting for a config, stepping slices, holding a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/product_accum_ctrl_if.sv
// Handshake bundle between the tile scheduler, multiplier array, product
// register array and downstream consumer on one side, and the controller on
// the other. The controller uses the slave view; its environment uses master.
interface product_accum_ctrl_if
    import product_accum_ctrl_pkg::*;
#(
    parameter int KW_P    = KW,
    parameter int TILE_CW = TILE_CW_DEF
);
    // Tile config side
    logic               cfg_valid;
    logic               cfg_ready;
    logic [KW_P-1:0]    cfg_klen;
    // Multiplier slice side
    logic               mul_valid;
    logic               mul_ready;
    // Product register array strobes
    logic               acc_clr;
    logic               acc_en;
    // Control and result side
    logic               abort;
    logic               res_valid;
    logic               res_ready;
    logic               busy;
    logic [TILE_CW-1:0] tile_cnt;

    modport slave (
        input  cfg_valid,
        input  cfg_klen,
        input  mul_valid,
        input  abort,
        input  res_ready,
        output cfg_ready,
        output mul_ready,
        output acc_clr,
        output acc_en,
        output res_valid,
        output busy,
        output tile_cnt
    );

    modport master (
        output cfg_valid,
        output cfg_klen,
        output mul_valid,
        output abort,
        output res_ready,
        input  cfg_ready,
        input  mul_ready,
        input  acc_clr,
        input  acc_en,
        input  res_valid,
        input  busy,
        input  tile_cnt
    );

endinterface

// File: rtl/product_accum_ctrl.sv
// Sequencer for the product/accumulator register array over one output tile.
// Takes a tile length from the scheduler, steps that many multiplier slices
// into the array (first slice overwrites, the rest accumulate), then holds the
// finished tile until downstream takes it. Back-to-back tiles can chain
// straight from DONE into ACCUM without an IDLE bubble.
module product_accum_ctrl
    import product_accum_ctrl_pkg::*;
#(
    parameter int K_MAX   = K_MAX_DEF,
    parameter int TILE_CW = TILE_CW_DEF
)(
    input  logic                 clk,
    input  logic                 rst,
    product_accum_ctrl_if.slave  bus
);

    // Slice counter / tile length width for this instance.
    localparam int KW_L = $clog2(K_MAX + 1);

    state_t              state_q,    state_d;
    logic [KW_L-1:0]     cnt_q,      cnt_d;
    logic [KW_L-1:0]     klen_q,     klen_d;
    logic [TILE_CW-1:0]  tile_cnt_q, tile_cnt_d;

    logic                cfg_ready;
    logic                mul_ready;
    logic                acc_en;
    logic                acc_clr;
    logic                res_valid;
    logic [KW_L-1:0]     cfg_klen_eff;
    logic                slice_last;

    // Normalise the offered tile length: zero means one slice, and anything
    // beyond the array's depth is clamped so the counter can never overrun.
    always_comb begin
        cfg_klen_eff = bus.cfg_klen;
        if (bus.cfg_klen == '0) begin
            cfg_klen_eff = KW_L'(1);
        end else if (bus.cfg_klen > KW_L'(K_MAX)) begin
            cfg_klen_eff = KW_L'(K_MAX);
        end
    end

    // The slice being offered now is the final one of the tile.
    assign slice_last = (cnt_q == (klen_q - KW_L'(1)));

    // Next-state and output decode; abort is applied last so it overrides
    // whatever the phase logic decided this cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        klen_d     = klen_q;
        tile_cnt_d = tile_cnt_q;
        cfg_ready  = 1'b0;
        mul_ready  = 1'b0;
        acc_en     = 1'b0;
        acc_clr    = 1'b0;
        res_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (bus.cfg_valid) begin
                    klen_d  = cfg_klen_eff;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                mul_ready = 1'b1;
                acc_en    = bus.mul_valid;
                // First slice of a tile replaces stale array contents.
                acc_clr   = bus.mul_valid && (cnt_q == '0);
                if (bus.mul_valid) begin
                    cnt_d = cnt_q + KW_L'(1);
                    if (slice_last) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // Array already holds the completed tile; keep it frozen.
                res_valid = 1'b1;
                cfg_ready = bus.res_ready;
                if (bus.res_ready) begin
                    tile_cnt_d = tile_cnt_q + TILE_CW'(1);
                    if (bus.cfg_valid) begin
                        // Chain the next tile with no IDLE bubble.
                        klen_d  = cfg_klen_eff;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (bus.abort) begin
            state_d    = IDLE;
            cnt_d      = '0;
            klen_d     = klen_q;
            tile_cnt_d = tile_cnt_q;
            acc_en     = 1'b0;
            acc_clr    = 1'b0;
            cfg_ready  = 1'b0;
        end
    end

    // Controller state: phase, slice count, latched tile length, tile counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            klen_q     <= KW_L'(1);
            tile_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            klen_q     <= klen_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.mul_ready = mul_ready;
    assign bus.acc_en    = acc_en;
    assign bus.acc_clr   = acc_clr;
    assign bus.res_valid = res_valid;
    assign bus.busy      = (state_q != IDLE);
    assign bus.tile_cnt  = tile_cnt_q;

endmodule
